// File: rtl/simpleproc_dmem_pkg.sv
// simpleproc_dmem_pkg: shared FSM encoding, counter width and parity helper for the data memory
package simpleproc_dmem_pkg;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;
  localparam int CNT_W = 4;
  // even parity bit; callers zero-extend narrower words, which leaves parity unchanged
  function automatic logic par(input logic [63:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/simpleproc_dmem_if.sv
// simpleproc_dmem_if: processor <-> data memory request/response bus
//   req_valid/req_ready/req_we/req_addr/req_wdata : request channel (master drives valid/we/addr/wdata)
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err         : response channel (slave drives valid/rdata/err)
//   err_inj                                       : parity error injection, only with SIMPLEPROC_DMEM_PARITY_EN
interface simpleproc_dmem_if #(parameter int DW = 8, parameter int AW = 8);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
`ifdef SIMPLEPROC_DMEM_PARITY_EN
  logic          err_inj;
`endif
  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
`ifdef SIMPLEPROC_DMEM_PARITY_EN
    output err_inj,
`endif
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
`ifdef SIMPLEPROC_DMEM_PARITY_EN
    input  err_inj,
`endif
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/simpleproc_dmem_array.sv
// simpleproc_dmem_array: single-port synchronous RAM, DEPTH x W, registered read
//   clk   : clock
//   we    : write enable
//   addr  : word index
//   wdata : write word
//   rdata : word at addr, one cycle after addr is presented
module simpleproc_dmem_array #(
  parameter int W     = 8,
  parameter int DEPTH = 256,
  parameter int IW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end
endmodule

// File: rtl/simpleproc_dmem.sv
// simpleproc_dmem: wait-stated data memory slave for the simple processor
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of simpleproc_dmem_if (request / response handshakes)
//   Optional SIMPLEPROC_DMEM_PARITY_EN: stores an even parity bit per word, adds bus.err_inj,
//   and flags parity mismatches on reads through rsp_err.
module simpleproc_dmem
  import simpleproc_dmem_pkg::*;
#(
  parameter int DW          = 8,
  parameter int AW          = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  simpleproc_dmem_if.slave bus
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
`ifdef SIMPLEPROC_DMEM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  logic [1:0]       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready, r_we, r_err;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata, r_rdata;
  logic             w_acc, w_oor, w_mem_we, w_par_err;
  logic [IW-1:0]    w_mem_addr;
  logic [MW-1:0]    w_mem_wdata, w_mem_rdata;
  assign w_acc = bus.req_valid & r_req_ready;
  assign w_oor = {1'b0, r_addr} >= (AW+1)'(DEPTH);
  assign w_mem_we = (r_state == ACCESS) & r_we & ~w_oor;
  // while idle the RAM looks at the live request address so its registered output
  // already holds the addressed word by the ACCESS cycle, even with zero wait states
  assign w_mem_addr = r_state == IDLE ? bus.req_addr[IW-1:0] : r_addr[IW-1:0];
`ifdef SIMPLEPROC_DMEM_PARITY_EN
  assign w_mem_wdata = {par(64'(r_wdata)) ^ bus.err_inj, r_wdata};
  assign w_par_err = ^w_mem_rdata;
`else
  assign w_mem_wdata = r_wdata;
  assign w_par_err = 1'b0;
`endif
  always_comb
    w_next = r_state == IDLE   ? (w_acc ? (WAIT_CYCLES == 0 ? ACCESS : WAIT) : IDLE) :
             r_state == WAIT   ? (r_cnt == CNT_W'(1) ? ACCESS : WAIT) :
             r_state == ACCESS ? RESP :
             bus.rsp_ready     ? IDLE : RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_req_ready <= 1'b0;
      r_cnt <= '0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_next;
      r_req_ready <= w_next == IDLE;
      if (w_acc) r_cnt <= CNT_W'(WAIT_CYCLES);
      else if (r_state == WAIT) r_cnt <= r_cnt - CNT_W'(1);
      if (r_state == ACCESS) begin
        r_err <= w_oor | (~r_we & w_par_err);
        r_rdata <= w_oor ? '0 : r_we ? r_rdata : w_mem_rdata[DW-1:0];
      end
    end
  end
  always_ff @(posedge clk)
    if (w_acc) begin
      r_we <= bus.req_we;
      r_addr <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err = r_err;
  simpleproc_dmem_array #(.W(MW), .DEPTH(DEPTH), .IW(IW)) u_array (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (w_mem_addr),
    .wdata (w_mem_wdata),
    .rdata (w_mem_rdata)
  );
endmodule

// File: tb/tb_simpleproc_dmem.sv
// tb_simpleproc_dmem: directed bench with a response scoreboard for simpleproc_dmem (DEPTH=128, WAIT_CYCLES=2)
module tb_simpleproc_dmem;
  localparam int DW = 8, AW = 8, DEPTH = 128, WC = 2;
  typedef struct packed {
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  exp_t q[$];
  logic [DW-1:0] mem_m [256];
  logic          bad_m [256];
  logic [DW-1:0] last_rd;
  logic          inj = 1'b0;
  simpleproc_dmem_if #(.DW(DW), .AW(AW)) bus ();
  simpleproc_dmem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
  always #5 clk = ~clk;
`ifdef SIMPLEPROC_DMEM_PARITY_EN
  assign bus.err_inj = inj;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one full transaction; expectation pushed at drive time, popped at the response
  task automatic xact(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int hold);
    exp_t e;
    int n;
    logic oor;
    oor = addr >= AW'(DEPTH);
    if (we) begin
      e.rd = oor ? '0 : last_rd;
      e.err = oor;
      if (!oor) begin
        mem_m[addr] = wd;
        bad_m[addr] = inj;
      end
    end else begin
      e.rd = oor ? '0 : mem_m[addr];
      e.err = oor | (!oor && bad_m[addr]);
    end
    last_rd = e.rd;
    q.push_back(e);
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    chk("idle_req_ready", 32'(bus.req_ready), 1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_we = ~we;
    bus.req_addr = ~addr;
    n = 1;
    chk("busy_req_ready", 32'(bus.req_ready), 0);
    while (!bus.rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), WC + 2);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", 32'(bus.rsp_valid), 1);
      chk("hold_rdata", 32'(bus.rsp_rdata), 32'(q[0].rd));
      chk("hold_req_ready", 32'(bus.req_ready), 0);
      tick();
    end
    e = q.pop_front();
    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rd));
    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("post_valid", 32'(bus.rsp_valid), 0);
    chk("post_req_ready", 32'(bus.req_ready), 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) bad_m[i] = 1'b0;
    last_rd = '0;
    // reset
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.rsp_valid), 0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 0);
    chk("rst_err", 32'(bus.rsp_err), 0);
    rst = 1'b0;
    tick();
    chk("release_req_ready", 32'(bus.req_ready), 1);
    // write then read
    xact(1'b1, 8'h10, 8'hA5, 0);
    xact(1'b0, 8'h10, 8'h00, 0);
    // backpressure
    xact(1'b0, 8'h10, 8'h00, 5);
    // range boundaries
    xact(1'b1, 8'h00, 8'h5A, 0);
    xact(1'b1, 8'h7F, 8'hC3, 1);
    xact(1'b1, 8'h80, 8'h3C, 0);
    xact(1'b0, 8'h80, 8'h00, 0);
    xact(1'b0, 8'hFF, 8'h00, 0);
    xact(1'b0, 8'h00, 8'h00, 0);
    xact(1'b0, 8'h7F, 8'h00, 0);
    // reset in the middle of a write
    xact(1'b1, 8'h20, 8'h55, 0);
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_addr = 8'h20;
    bus.req_wdata = 8'h77;
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 6; i++) begin
      chk("abort_no_rsp", 32'(bus.rsp_valid), 0);
      tick();
    end
    chk("abort_rdata", 32'(bus.rsp_rdata), 0);
    xact(1'b0, 8'h20, 8'h00, 0);
    xact(1'b0, 8'h10, 8'h00, 2);
`ifdef SIMPLEPROC_DMEM_PARITY_EN
    inj = 1'b1;
    xact(1'b1, 8'h05, 8'h0F, 0);
    inj = 1'b0;
    xact(1'b0, 8'h05, 8'h00, 0);
    xact(1'b1, 8'h05, 8'h0F, 0);
    xact(1'b0, 8'h05, 8'h00, 0);
`endif
    chk("scoreboard_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
